// File: rtl/vector_serializer.sv
`default_nettype none
// ============================================================================
// Module   : vector_serializer
// Brief    : Captures a SIZE-word signed vector in one cycle and streams it
//            out one word per valid/ready transfer, element 0 first.
// Revision : 1.0 - initial release
// ============================================================================
module vector_serializer #(
  parameter int WIDTH   = 16,
  parameter int SIZE    = 64,
  parameter int LOGSIZE = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic signed [WIDTH-1:0] load_data [SIZE-1:0],
  input  logic        [LOGSIZE:0] load_len,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy
);

  localparam logic [0:0]       c_st_idle   = 1'b0;
  localparam logic [0:0]       c_st_stream = 1'b1;
  localparam logic [LOGSIZE:0] c_size_len  = (LOGSIZE+1)'(SIZE);

  logic [0:0]              r_state;
  logic [LOGSIZE-1:0]      r_index;
  logic [LOGSIZE-1:0]      r_last_idx;
  logic signed [WIDTH-1:0] r_buf [SIZE-1:0];
  logic signed [WIDTH-1:0] r_out_data;
  logic                    r_out_valid;
  logic                    r_out_last;

  logic                    w_xfer;
  logic                    w_load;
  logic [LOGSIZE:0]        w_len_eff;
  logic [LOGSIZE-1:0]      w_len_last_idx;
  logic [LOGSIZE-1:0]      w_next_idx;

  logic [0:0]              w_state_nxt;
  logic [LOGSIZE-1:0]      w_index_nxt;
  logic [LOGSIZE-1:0]      w_last_idx_nxt;
  logic signed [WIDTH-1:0] w_data_nxt;
  logic                    w_valid_nxt;
  logic                    w_last_nxt;

  // load_ready reopens on the final transfer so a new vector follows with no bubble
  always_comb begin
    w_xfer     = r_out_valid && out_ready;
    load_ready = (r_state == c_st_idle) || (w_xfer && r_out_last);
    w_load     = load_valid && load_ready;
  end

  // A zero or oversized length means the whole vector
  always_comb begin
    if ((load_len == '0) || (load_len > c_size_len)) begin
      w_len_eff = c_size_len;
    end else begin
      w_len_eff = load_len;
    end
    w_len_last_idx = LOGSIZE'(w_len_eff - (LOGSIZE+1)'(1));
    w_next_idx     = r_index + LOGSIZE'(1);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_index_nxt    = r_index;
    w_last_idx_nxt = r_last_idx;
    w_data_nxt     = r_out_data;
    w_valid_nxt    = r_out_valid;
    w_last_nxt     = r_out_last;
    if (w_load) begin
      // Word 0 comes straight from the load bus so it is valid the next cycle
      w_state_nxt    = c_st_stream;
      w_index_nxt    = '0;
      w_last_idx_nxt = w_len_last_idx;
      w_data_nxt     = load_data[0];
      w_valid_nxt    = 1'b1;
      w_last_nxt     = (w_len_last_idx == '0);
    end else if (w_xfer) begin
      if (r_out_last) begin
        w_state_nxt = c_st_idle;
        w_index_nxt = '0;
        w_data_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end else begin
        w_index_nxt = w_next_idx;
        w_data_nxt  = r_buf[w_next_idx];
        w_last_nxt  = (w_next_idx == r_last_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_st_idle;
      r_index     <= '0;
      r_last_idx  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_index     <= w_index_nxt;
      r_last_idx  <= w_last_idx_nxt;
      r_out_data  <= w_data_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_last  <= w_last_nxt;
    end
  end

  // The buffer is only written on an accepted load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SIZE; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_load) begin
      for (int i = 0; i < SIZE; i++) begin
        r_buf[i] <= load_data[i];
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state == c_st_stream);

endmodule
`default_nettype wire

// File: tb/tb_vector_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_serializer
// Brief    : Self-checking bench for vector_serializer: table vectors, corner
//            sequences and random traffic against a queue-based word model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_serializer;

  localparam int WIDTH   = 16;
  localparam int SIZE    = 4;
  localparam int LOGSIZE = 2;

  typedef logic signed [WIDTH-1:0] word_t;
  typedef struct {
    word_t            d [SIZE];
    logic [LOGSIZE:0] len;
    int               exp_n;
  } vec_t;

  logic             clk        = 1'b0;
  logic             reset_n    = 1'b1;
  logic             load_valid = 1'b0;
  logic             out_ready  = 1'b0;
  logic [LOGSIZE:0] load_len   = '0;
  word_t            load_data [SIZE-1:0];
  word_t            out_data;
  logic             out_valid;
  logic             out_last;
  logic             load_ready;
  logic             busy;

  int    n_chk = 0;
  int    n_err = 0;
  int    valid_cycles;
  word_t mq [$];
  word_t got [$];
  bit    got_last [$];
  vec_t  tbl [6];

  always #5 clk = ~clk;

  vector_serializer #(
    .WIDTH   (WIDTH),
    .SIZE    (SIZE),
    .LOGSIZE (LOGSIZE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff_len(input int len);
    return ((len == 0) || (len > SIZE)) ? SIZE : len;
  endfunction

  // One cycle: called just after a negedge with inputs already driven
  task automatic tick();
    bit    m_valid;
    bit    m_lr;
    bit    fire;
    int    n;
    word_t snap [SIZE];
    #1;
    m_valid = (mq.size() > 0);
    m_lr    = (mq.size() == 0) || ((mq.size() == 1) && out_ready);
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, m_valid);
    chk("load_ready", load_ready, m_lr);
    chk("out_last", out_last, (mq.size() == 1));
    if (m_valid) chk("out_data", out_data, mq[0]);
    if (out_valid === 1'b1) valid_cycles++;
    if ((out_valid === 1'b1) && out_ready) begin
      got.push_back(out_data);
      got_last.push_back(out_last);
    end
    fire = load_valid && m_lr;
    n    = eff_len(int'(load_len));
    for (int i = 0; i < SIZE; i++) snap[i] = load_data[i];
    @(posedge clk);
    if (m_valid && out_ready) void'(mq.pop_front());
    if (fire) for (int i = 0; i < n; i++) mq.push_back(snap[i]);
    @(negedge clk);
  endtask

  task automatic drive_vec(input vec_t v);
    for (int i = 0; i < SIZE; i++) load_data[i] = v.d[i];
    load_len = v.len;
  endtask

  task automatic clear_log();
    got.delete();
    got_last.delete();
    valid_cycles = 0;
  endtask

  task automatic check_words(input string name, input vec_t v, input int base);
    for (int i = 0; i < v.exp_n; i++) begin
      if (base + i < got.size()) begin
        chk({name, " word"}, got[base+i], v.d[i]);
        chk({name, " last"}, got_last[base+i], (i == v.exp_n - 1));
      end else begin
        chk({name, " missing word"}, base + i, got.size());
      end
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    clear_log();
    drive_vec(v);
    load_valid = 1'b1;
    out_ready  = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < SIZE + 3; k++) tick();
    chk({name, " count"}, got.size(), v.exp_n);
    chk({name, " valid cycles"}, valid_cycles, v.exp_n);
    check_words(name, v, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t w;
    for (int i = 0; i < SIZE; i++) load_data[i] = '0;
    tbl[0].d = '{16'sd10, -16'sd3, 16'sd7, 16'sh7FFF};  tbl[0].len = 3'd4; tbl[0].exp_n = 4;
    tbl[1].d = '{16'sd10, -16'sd3, 16'sd7, 16'sh7FFF};  tbl[1].len = 3'd2; tbl[1].exp_n = 2;
    tbl[2].d = '{16'sd10, -16'sd3, 16'sd7, 16'sh7FFF};  tbl[2].len = 3'd0; tbl[2].exp_n = 4;
    tbl[3].d = '{16'sd10, -16'sd3, 16'sd7, 16'sh7FFF};  tbl[3].len = 3'd7; tbl[3].exp_n = 4;
    tbl[4].d = '{-16'sd32768, 16'sd5, 16'sd6, 16'sd7};  tbl[4].len = 3'd1; tbl[4].exp_n = 1;
    tbl[5].d = '{16'sd0, -16'sd1, 16'sd100, -16'sd100}; tbl[5].len = 3'd3; tbl[5].exp_n = 3;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_last", out_last, 0);
    chk("reset out_data", out_data, 0);
    chk("reset busy", busy, 0);
    chk("reset load_ready", load_ready, 1);
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    tick();

    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Backpressure on word 1
    clear_log();
    drive_vec(tbl[0]);
    load_valid = 1'b1; out_ready = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp held data", out_data, -3);
      chk("bp held valid", out_valid, 1);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("bp count", got.size(), 4);
    check_words("bp", tbl[0], 0);

    // Back-to-back vectors A then B with load_valid held
    w.d = '{16'sd1, 16'sd2, 16'sd3, 16'sd4}; w.len = 3'd4; w.exp_n = 4;
    clear_log();
    drive_vec(w);
    load_valid = 1'b1; out_ready = 1'b1;
    tick();
    w.d = '{16'sd5, 16'sd6, 16'sd7, 16'sd8};
    drive_vec(w);
    for (int k = 0; k < 4; k++) tick();
    load_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("b2b valid cycles", valid_cycles, 8);
    chk("b2b count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        chk("b2b word", got[i], i + 1);
        chk("b2b last", got_last[i], (i == 3) || (i == 7));
      end
    end
    tick();
    chk("b2b idle after", out_valid, 0);

    // Load offered mid-stream is ignored until load_ready rises
    clear_log();
    drive_vec(tbl[0]);
    load_valid = 1'b1; out_ready = 1'b1;
    tick();
    w.d = '{-16'sd1, -16'sd2, -16'sd3, -16'sd4};
    drive_vec(w);
    tick();
    tick();
    tick();
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("ign count", got.size(), 8);
    check_words("ign orig", tbl[0], 0);
    check_words("ign new", w, 4);

    // Asynchronous reset while word 2 is presented
    clear_log();
    drive_vec(tbl[0]);
    load_valid = 1'b1; out_ready = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    #3 reset_n = 1'b0;
    #1;
    chk("rst mid out_valid", out_valid, 0);
    chk("rst mid out_last", out_last, 0);
    chk("rst mid out_data", out_data, 0);
    chk("rst mid busy", busy, 0);
    chk("rst mid load_ready", load_ready, 1);
    mq.delete();
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst mid words before abort", got.size(), 2);
    run_vec("post reset", tbl[5]);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      load_valid = ($urandom % 2) == 0;
      out_ready  = ($urandom % 4) != 0;
      load_len   = 3'($urandom_range(0, 7));
      for (int i = 0; i < SIZE; i++) load_data[i] = word_t'($urandom);
      tick();
    end
    load_valid = 1'b0;
    out_ready  = 1'b1;
    for (int k = 0; k < SIZE + 3; k++) tick();
    chk("drained", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
